// File: rtl/sh_onchip_ram_ws_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sh_onchip_ram_ws_if
// Purpose  : SH internal-bus (IBUS) signal bundle between a bus master and the on-chip RAM.
// Revision : 1.0
// ============================================================================
interface sh_onchip_ram_ws_if;
   logic [27:0] ibus_a;
   logic [31:0] ibus_di;
   logic [31:0] ibus_do;
   logic [3:0]  ibus_ba;
   logic        ibus_we;
   logic        ibus_req;
   logic        ibus_busy;
   logic        ibus_act;

   modport master (
      output ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
      input  ibus_do, ibus_busy, ibus_act
   );

   modport slave (
      input  ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req,
      output ibus_do, ibus_busy, ibus_act
   );
endinterface
`default_nettype wire

// File: rtl/sh_onchip_ram_ws.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sh_onchip_ram_ws
// Purpose  : Byte-lane IBUS RAM with programmable wait states and write-snoop debug channels.
// Revision : 1.0
// ============================================================================
module sh_onchip_ram_ws #(
   parameter int unsigned                      ADDR_W      = 10,
   parameter logic [3:0]                       BASE        = 4'hF,
   parameter int unsigned                      WAIT_STATES = 0,
   parameter int unsigned                      SNOOP_N     = 6,
   parameter logic [SNOOP_N*(ADDR_W+2)-1:0]    SNOOP_ADDR  = '0,
   parameter logic [SNOOP_N*2-1:0]             SNOOP_LANE  = '0
) (
   input  wire logic                  clk_i,
   input  wire logic                  rst_n_i,
   input  wire logic                  ce_r_i,
   input  wire logic                  ce_f_i,
   sh_onchip_ram_ws_if.slave          bus,
   output logic [SNOOP_N*8-1:0]       dbg_snoop_o,
   output logic [SNOOP_N-1:0]         dbg_snoop_upd_o
);

   localparam int unsigned CNT_W    = 4;
   localparam logic        HAS_WAIT = (WAIT_STATES != 0);
   localparam logic [CNT_W-1:0] WS_LOAD = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       do_q;
   logic [31:0]       mem_q [0:(2**ADDR_W)-1];

   logic              ram_sel;
   logic              busy;
   logic              fin;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] word_addr;
   logic              unused_ok;

   assign ram_sel   = (bus.ibus_a[27:24] == BASE);
   assign word_addr = bus.ibus_a[ADDR_W+1:2];
   // Upper in-region bits alias the image; CE_F is reserved.
   assign unused_ok = ^{ce_f_i, bus.ibus_a[23:ADDR_W+2], bus.ibus_a[1:0]};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // fin marks the final tick of an access: the cycle in which it commits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.ibus_req && ram_sel) begin
               busy = HAS_WAIT;
               if (ce_r_i) begin
                  if (HAS_WAIT) begin
                     state_d = ST_WAIT;
                     cnt_d   = WS_LOAD;
                  end else begin
                     fin = 1'b1;
                  end
               end
            end
         end
         ST_WAIT: begin
            busy = (cnt_q != '0);
            if (ce_r_i) begin
               if (cnt_q == '0) begin
                  fin     = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // rst_n_i gating keeps a zero-wait access from committing while reset is held.
   assign wr_en = fin && bus.ibus_we && rst_n_i;
   assign rd_en = fin && !bus.ibus_we;

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.ibus_ba[k]) begin
               mem_q[word_addr][8*k +: 8] <= bus.ibus_di[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         do_q <= '0;
      end else if (rd_en) begin
         do_q <= mem_q[word_addr];
      end
   end

   assign bus.ibus_do   = do_q;
   assign bus.ibus_busy = busy;
   assign bus.ibus_act  = ram_sel;

   for (genvar i = 0; i < SNOOP_N; i++) begin : g_snoop
      localparam logic [ADDR_W-1:0] CH_WORD = SNOOP_ADDR[i*(ADDR_W+2)+2 +: ADDR_W];
      localparam logic [1:0]        CH_LANE = SNOOP_LANE[2*i +: 2];

      logic       hit;
      logic [7:0] byte_q;
      logic       upd_q;

      assign hit = wr_en && (word_addr == CH_WORD) && bus.ibus_ba[CH_LANE];

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            byte_q <= '0;
            upd_q  <= 1'b0;
         end else begin
            upd_q <= hit;
            if (hit) begin
               byte_q <= bus.ibus_di[8*CH_LANE +: 8];
            end
         end
      end

      assign dbg_snoop_o[8*i +: 8] = byte_q;
      assign dbg_snoop_upd_o[i]    = upd_q;
   end

endmodule
`default_nettype wire
